mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single memory bus port between instruction fetch (I side) and the MEM-stage data access (D side). It sits between the fetch/MEM stages and the bus, and grants one requester at a time. The grant is held until the bus returns a response. D has priority, and a bounded fairness counter keeps I from starving. While a requester waits for its grant or its response, its request stays unacknowledged, and the hazard unit sees that as a stall.

## Interface
- `ADDR_W`, 64, request address width
- `DATA_W`, 64, data width
- `STARVE_MAX`, 4, maximum consecutive D grants while I is pending; range 1–15
- `clk` in 1: the single clock
- `resetn` in 1: reset, asynchronous and active-low
- `i_req_valid` in 1: fetch request; held high until `i_resp_ok`
- `i_req_addr` in ADDR_W: fetch address
- `i_resp_ok` out 1: one-cycle pulse that completes the fetch
- `i_resp_data` out DATA_W: fetch data, valid with `i_resp_ok`
- `d_req_valid` in 1: data request; held high until `d_resp_ok`
- `d_req_write` in 1: 1 for a store
- `d_req_addr` in ADDR_W: data address
- `d_req_size` in 3: access size code, passed through unchanged
- `d_req_strobe` in DATA_W/8: byte strobes for a store
- `d_req_data` in DATA_W: store data
- `d_resp_ok` out 1: one-cycle pulse that completes the data access
- `d_resp_data` out DATA_W: load data, valid with `d_resp_ok`
- `m_req_valid` out 1: bus request
- `m_req_write` out 1: bus write flag
- `m_req_addr` out ADDR_W: bus address
- `m_req_size` out 3: bus access size
- `m_req_strobe` out DATA_W/8: bus byte strobes
- `m_req_data` out DATA_W: bus write data
- `m_resp_ok` in 1: bus response pulse
- `m_resp_data` in DATA_W: bus read data
- `owner` out 2: current owner, 0 = none, 1 = I, 2 = D

## Operation
- States:
  - IDLE: no owner.
  - GRANT_I: I owns the bus.
  - GRANT_D: D owns the bus.
  - DRAIN: an aborted fetch is still outstanding on the bus.
- Arbitration happens in IDLE only:
  - Only one side valid: that side wins.
  - Both valid: D wins, unless `d_streak == STARVE_MAX`; then I wins.
- On a grant, all request fields of the winner are latched into registers. I grants drive `m_req_write=0`, `m_req_size=3'b011`, `m_req_strobe=0` and `m_req_data=0`.
- `m_*` outputs come only from the latched registers. Later changes on the requester's inputs are ignored until completion.
- `d_streak` is a 4-bit register, updated at each grant:
  - D granted while `i_req_valid=1`: increments, saturating at STARVE_MAX.
  - D granted while `i_req_valid=0`: cleared.
  - I granted: cleared.
- GRANT_x, response: on `m_resp_ok`, pulse `x_resp_ok` for that cycle and drive `x_resp_data = m_resp_data` combinationally. Next state is IDLE.
- GRANT_I, fetch abort: `i_req_valid` low before `m_resp_ok` (branch flush) → go to DRAIN. `m_req_valid` stays asserted with the same latched fields.
- DRAIN: on `m_resp_ok`, the response is swallowed and `i_resp_ok` stays 0. Next state is IDLE.
- GRANT_D: `d_req_valid` must not drop before `d_resp_ok`. If it does, the transaction still completes and `d_resp_ok` still pulses.
- `m_resp_ok` in IDLE is ignored.
- `i_resp_ok` and `d_resp_ok` are never high in the same cycle.

## Timing
- Reset (`resetn` low, asynchronous): state IDLE, `d_streak=0`, all latched fields 0. Every output is 0: `m_req_valid`, `i_resp_ok`, `d_resp_ok`, `owner`, and all data and address outputs. No partial transaction survives a mid-transfer reset.
- Request sampled high in IDLE at cycle t → grant registered → `m_req_valid=1` and `owner` updated at t+1.
- `m_resp_ok` at cycle k → `x_resp_ok` at cycle k (zero latency) → IDLE at k+1.
- Earliest next grant is registered at k+1, so the next `m_req_valid` is at k+2. There is always one idle bus cycle between transactions.
- Minimum request-to-response latency is 1 cycle plus bus latency.
- All state and `d_streak` updates happen on the rising edge of `clk`. Response routing is purely combinational from `m_resp_ok` and the state.

## Test plan
- Reset mid-transfer: pull `resetn` low while in GRANT_D → `m_req_valid`, `owner` and `d_streak` are 0 at once, asynchronously. After release with no requests, all outputs stay 0.
- Single fetch: `i_req_valid=1`, addr `0x8000_0000` at t; bus responds with `0x0000_0013_0000_0093` 3 cycles after the request → `m_req_valid` from t+1, `i_resp_ok=1` with that data for exactly one cycle, `owner` 0 the next cycle.
- Simultaneous requests: I and D valid at t, D a store of `0xDEAD_BEEF` to `0x8000_1000` with strobe `0x0F` → D granted first with `m_req_write=1` and the exact strobe and data. I is granted 2 cycles after `d_resp_ok`.
- Starvation limit: I held valid while D issues back-to-back requests, `STARVE_MAX=4` → 4 D transactions complete, the 5th grant goes to I, then `d_streak` reads 0.
- Fetch abort: drop `i_req_valid` 1 cycle after the I grant → `m_req_valid` held until `m_resp_ok`, `i_resp_ok` never pulses, state IDLE the cycle after the response.
- Field stability: change `d_req_addr` during GRANT_D → `m_req_addr` keeps the latched value until completion.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus port between instruction fetch (I)
// and MEM-stage data access (D). One owner at a time, grant held until the bus
// responds. D wins ties unless it has already taken STARVE_MAX grants in a row
// while I was waiting. A flushed fetch is drained so its late response is
// swallowed instead of being delivered to the fetch stage.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_req_valid,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_ok,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  input  logic                d_req_write,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [2:0]          d_req_size,
  input  logic [DATA_W/8-1:0] d_req_strobe,
  input  logic [DATA_W-1:0]   d_req_data,
  output logic                d_resp_ok,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                m_req_valid,
  output logic                m_req_write,
  output logic [ADDR_W-1:0]   m_req_addr,
  output logic [2:0]          m_req_size,
  output logic [DATA_W/8-1:0] m_req_strobe,
  output logic [DATA_W-1:0]   m_req_data,
  input  logic                m_resp_ok,
  input  logic [DATA_W-1:0]   m_resp_data,
  output logic [1:0]          owner
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] STREAK_MAX = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} state_t;

  // Latched bus request; the bus only ever sees these registers.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } bus_req_t;

  state_t   state, state_nxt;
  bus_req_t req_q, req_nxt;
  logic [3:0] d_streak, d_streak_nxt;
  logic       d_wins;

  // D wins a tie unless I has been passed over STARVE_MAX times in a row.
  assign d_wins = d_req_valid && !(i_req_valid && (d_streak == STREAK_MAX));

  // Next-state, grant latching, streak update and response routing.
  always_comb begin
    state_nxt    = state;
    req_nxt      = req_q;
    d_streak_nxt = d_streak;
    i_resp_ok    = 1'b0;
    d_resp_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (d_wins) begin
          state_nxt      = GRANT_D;
          req_nxt.write  = d_req_write;
          req_nxt.addr   = d_req_addr;
          req_nxt.size   = d_req_size;
          req_nxt.strobe = d_req_strobe;
          req_nxt.data   = d_req_data;
          if (!i_req_valid)                d_streak_nxt = 4'd0;
          else if (d_streak != STREAK_MAX) d_streak_nxt = d_streak + 4'd1;
        end else if (i_req_valid) begin
          state_nxt      = GRANT_I;
          req_nxt.write  = 1'b0;
          req_nxt.addr   = i_req_addr;
          req_nxt.size   = 3'b011;
          req_nxt.strobe = '0;
          req_nxt.data   = '0;
          d_streak_nxt   = 4'd0;
        end
      end
      GRANT_I: begin
        // A response in the same cycle as a flush still completes the fetch.
        if (m_resp_ok) begin
          i_resp_ok = 1'b1;
          state_nxt = IDLE;
        end else if (!i_req_valid) begin
          state_nxt = DRAIN;
        end
      end
      GRANT_D: begin
        // D is not allowed to abort; complete regardless of d_req_valid.
        if (m_resp_ok) begin
          d_resp_ok = 1'b1;
          state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // Swallow the response of the flushed fetch.
        if (m_resp_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request and streak registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      req_q    <= '0;
      d_streak <= 4'd0;
    end else begin
      state    <= state_nxt;
      req_q    <= req_nxt;
      d_streak <= d_streak_nxt;
    end
  end

  // Bus drive and owner report, all from registered state.
  always_comb begin
    m_req_valid  = (state != IDLE);
    m_req_write  = req_q.write;
    m_req_addr   = req_q.addr;
    m_req_size   = req_q.size;
    m_req_strobe = req_q.strobe;
    m_req_data   = req_q.data;
    i_resp_data  = i_resp_ok ? m_resp_data : '0;
    d_resp_data  = d_resp_ok ? m_resp_data : '0;
    case (state)
      GRANT_I, DRAIN: owner = 2'd1;
      GRANT_D:        owner = 2'd2;
      default:        owner = 2'd0;
    endcase
  end

endmodule
